// File: rtl/tt3515_pkg.sv
// Shared constants for the programmable sequence detector: segment patterns
// and the hex glyph table used by the 7-segment display path.
package tt3515_pkg;

    // Segment encodings: bit 0 = a ... bit 6 = g, bit 7 = decimal point.
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_ALL  = 8'hFF;

    // Hex glyphs 0..F, entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to 7-segment glyph lookup (segments a..g on bits 0..6).
module seg7_hex_decoder
    import tt3515_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Pure table lookup.
    always_comb begin
        seg_o = HEX_GLYPH[hex_i];
    end

endmodule

// File: rtl/tt_um_3515_prog_seq_detector.sv
// Programmable serial sequence detector with match counter, sticky overflow
// flag, detect hold timer and 7-segment readout.
module tt_um_3515_prog_seq_detector
    import tt3515_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned HOLD_W  = 3,
    parameter logic [7:0]  PAT_RST = 8'h04,
    parameter int unsigned LEN_RST = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned LenW = $clog2(MAX_LEN + 1);

    logic x_in, valid_in, load_in, ovl_in, sel_in;

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] len_mask;
    logic [LenW-1:0]    len_q, len_d;
    logic [LenW-1:0]    fill_q, fill_d, fill_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               det_q, det_d;
    logic               match;

    logic [3:0]         len_field, len_sat;
    logic [CNT_W+3:0]   cnt_ext;
    logic [3:0]         cnt_low;
    logic [6:0]         glyph;

    assign x_in     = ui_in[0];
    assign valid_in = ui_in[1];
    assign load_in  = ui_in[2];
    assign ovl_in   = ui_in[3];
    assign sel_in   = ui_in[7];

    // Length field is length-1; clamp to what the history can hold.
    always_comb begin
        len_field = {1'b0, ui_in[6:4]} + 4'd1;
        len_sat   = (len_field > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len_field;
    end

    // Mask selecting the low len bits of history/pattern for comparison.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LenW'(i) < len_q);
        end
    end

    // Next-state: load beats valid; match is judged on the post-shift history.
    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        hist_d   = hist_q;
        fill_nxt = fill_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        hold_d   = hold_q;
        det_d    = 1'b0;
        match    = 1'b0;

        if (load_in) begin
            pat_d  = uio_in[MAX_LEN-1:0];
            len_d  = LenW'(len_sat);
            fill_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            hold_d = '0;
        end else begin
            if (valid_in) begin
                hist_d   = {hist_q[MAX_LEN-2:0], x_in};
                fill_nxt = (fill_q == LenW'(MAX_LEN)) ? fill_q : fill_q + LenW'(1);
                match    = (fill_nxt >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);
                // Non-overlapping mode demands a fresh len samples for the next hit.
                fill_d   = (match && !ovl_in) ? '0 : fill_nxt;
            end

            det_d = match;
            if (match) begin
                cnt_d  = cnt_q + CNT_W'(1);
                hold_d = '1;
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                end
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q  <= PAT_RST[MAX_LEN-1:0];
            len_q  <= LenW'(LEN_RST);
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            hold_q <= '0;
            det_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            hold_q <= hold_d;
            det_q  <= det_d;
        end
    end

    // Zero-extend so counters narrower than a nibble still display.
    assign cnt_ext = {4'b0000, cnt_q};
    assign cnt_low = cnt_ext[3:0];

    seg7_hex_decoder u_hex_dec (
        .hex_i (cnt_low),
        .seg_o (glyph)
    );

    // Display mux: count glyph with overflow dp, or hold indicator.
    always_comb begin
        if (sel_in) begin
            uo_out = (hold_q != '0) ? SEG_ALL : SEG_DASH;
        end else begin
            uo_out = {ovf_q, glyph};
        end
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Enable, unused pattern bits and the internal detect pulse have no sink.
    logic unused_sigs;
    assign unused_sigs = ^{ena, uio_in, det_q};

endmodule

// File: tb/tb_tt_um_3515_prog_seq_detector.sv
// Bench for the programmable sequence detector: directed scenarios plus a
// random phase, checked against a behavioural model through a scoreboard.
module tb_tt_um_3515_prog_seq_detector;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_total;
    int n_bad;

    logic [7:0] exp_q[$];

    // Model state.
    logic [7:0] m_pat;
    int         m_len;
    logic [7:0] m_hist;
    int         m_fill;
    int         m_cnt;
    bit         m_ovf;
    int         m_hold;

    logic [6:0] glyph_tbl [16];

    tt_um_3515_prog_seq_detector dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_step(input bit rst, input bit x, input bit valid,
                                       input bit load, input bit ovl, input bit [2:0] lenf,
                                       input logic [7:0] pat);
        bit hit;
        if (!rst) begin
            m_pat = 8'h04; m_len = 3; m_hist = '0; m_fill = 0;
            m_cnt = 0; m_ovf = 0; m_hold = 0;
        end else if (load) begin
            m_pat  = pat;
            m_len  = (int'(lenf) + 1 > 8) ? 8 : int'(lenf) + 1;
            m_fill = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
        end else begin
            hit = 0;
            if (valid) begin
                m_hist = {m_hist[6:0], x};
                if (m_fill < 8) m_fill++;
                if (m_fill >= m_len) begin
                    hit = 1;
                    for (int i = 0; i < m_len; i++)
                        if (m_hist[i] != m_pat[i]) hit = 0;
                end
                if (hit && !ovl) m_fill = 0;
            end
            if (hit) begin
                if (m_cnt == 15) m_ovf = 1;
                m_cnt  = (m_cnt + 1) % 16;
                m_hold = 7;
            end else if (m_hold > 0) begin
                m_hold--;
            end
        end
    endfunction

    function automatic logic [7:0] model_out(input bit sel);
        if (sel) return (m_hold != 0) ? 8'hFF : 8'h40;
        return {m_ovf, glyph_tbl[m_cnt]};
    endfunction

    // One clock: drive at the falling edge, compare just after the rising edge.
    task automatic drive(input string tag, input bit rst, input bit x, input bit valid,
                         input bit load, input bit ovl, input bit [2:0] lenf,
                         input bit sel, input logic [7:0] pat);
        logic [7:0] e;
        @(negedge clk);
        rst_n  = rst;
        ui_in  = {sel, lenf, ovl, load, valid, x};
        uio_in = pat;
        model_step(rst, x, valid, load, ovl, lenf, pat);
        exp_q.push_back(model_out(sel));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, uo_out, e);
        end
        check_eq("uio_out", uio_out, 8'h00);
        check_eq("uio_oe", uio_oe, 8'h00);
    endtask

    task automatic do_reset(input bit sel);
        drive("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, sel, 8'h00);
    endtask

    task automatic sample(input bit x, input bit ovl, input bit sel);
        drive("sample", 1'b1, x, 1'b1, 1'b0, ovl, 3'd0, sel, 8'h00);
    endtask

    task automatic idle(input bit sel);
        drive("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, sel, 8'h00);
    endtask

    task automatic do_load(input logic [7:0] pat, input bit [2:0] lenf, input bit sel);
        drive("load", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, lenf, sel, pat);
    endtask

    task automatic seq100(input bit ovl, input bit sel);
        sample(1'b1, ovl, sel);
        sample(1'b0, ovl, sel);
        sample(1'b0, ovl, sel);
    endtask

    initial begin
        int ff_cycles;
        glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        n_total = 0;
        n_bad   = 0;
        ena     = 1'b1;
        rst_n   = 1'b0;
        ui_in   = 8'h00;
        uio_in  = 8'h00;
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);

        // Reset values on both display selects.
        do_reset(1'b0);
        check_eq("rst_sel0", uo_out, 8'h3F);
        do_reset(1'b1);
        check_eq("rst_sel1", uo_out, 8'h40);

        // Default pattern 1,0,0.
        do_reset(1'b0);
        sample(1'b1, 1'b1, 1'b0);
        sample(1'b0, 1'b1, 1'b0);
        check_eq("dflt_before", uo_out, 8'h3F);
        sample(1'b0, 1'b1, 1'b0);
        check_eq("dflt_hit", uo_out, 8'h06);

        // Pattern 101, overlapping then non-overlapping.
        do_load(8'h05, 3'd2, 1'b0);
        sample(1'b1, 1'b1, 1'b0); sample(1'b0, 1'b1, 1'b0); sample(1'b1, 1'b1, 1'b0);
        sample(1'b0, 1'b1, 1'b0); sample(1'b1, 1'b1, 1'b0);
        check_eq("ovl1_cnt2", uo_out, 8'h5B);
        do_load(8'h05, 3'd2, 1'b0);
        sample(1'b1, 1'b0, 1'b0); sample(1'b0, 1'b0, 1'b0); sample(1'b1, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b0); sample(1'b1, 1'b0, 1'b0);
        check_eq("ovl0_cnt1", uo_out, 8'h06);

        // 16 detects wrap the counter and set the sticky overflow.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) seq100(1'b0, 1'b0);
        check_eq("wrap_ovf", uo_out, 8'hBF);
        idle(1'b0);
        check_eq("ovf_sticky", uo_out, 8'hBF);
        do_load(8'h04, 3'd2, 1'b0);
        check_eq("load_clr", uo_out, 8'h3F);

        // Hold display: 7 cycles, then retrigger mid-hold.
        do_reset(1'b1);
        seq100(1'b0, 1'b1);
        check_eq("hold_start", uo_out, 8'hFF);
        ff_cycles = 1;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            if (uo_out == 8'hFF) ff_cycles++;
        end
        check_eq("hold_len", 8'(ff_cycles), 8'd7);
        seq100(1'b0, 1'b1);
        idle(1'b1); idle(1'b1); idle(1'b1);
        seq100(1'b0, 1'b1);
        ff_cycles = 1;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            if (uo_out == 8'hFF) ff_cycles++;
        end
        check_eq("rehold_len", 8'(ff_cycles), 8'd7);

        // Load with valid: sample with x=1 is dropped.
        do_reset(1'b0);
        drive("load_valid", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 8'h04);
        sample(1'b0, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b0);
        check_eq("drop_sample", uo_out, 8'h3F);
        seq100(1'b0, 1'b0);
        check_eq("after_drop", uo_out, 8'h06);

        // Reset abandons a partial sequence.
        do_reset(1'b0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b0);
        do_reset(1'b0);
        sample(1'b0, 1'b0, 1'b0);
        check_eq("rst_abandon", uo_out, 8'h3F);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit         r_rst, r_load, r_valid;
            logic [7:0] r_pat;
            r_rst   = ($urandom_range(0, 99) != 0);
            r_load  = ($urandom_range(0, 24) == 0);
            r_valid = ($urandom_range(0, 2) != 0);
            r_pat   = 8'($urandom);
            drive("rand", r_rst, 1'($urandom), r_valid, r_load, 1'($urandom),
                  3'($urandom_range(0, 3)), 1'($urandom), r_pat);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_um_3515_prog_seq_detector.md
TT_UM_3515_PROG_SEQ_DETECTOR -- requirements
Module: tt_um_3515_prog_seq_detector

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..8.
REQ-002 Parameter CNT_W, default 4: match-counter width in bits.
REQ-003 Parameter HOLD_W, default 3: detect-display hold counter width; hold time is 2^HOLD_W-1 cycles.
REQ-004 Parameter PAT_RST, default 8'h04: pattern after reset.
REQ-005 Parameter LEN_RST, default 3: pattern length after reset, giving sequence 1,0,0.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 ena  input  1  design enable; ignored by the logic.
REQ-009 ui_in  input  8  [0] x serial bit; [1] valid sample strobe; [2] load strobe; [3] overlap mode (1=overlapping); [6:4] length-1; [7] display select.
REQ-010 uio_in  input  8  pattern value, sampled on load.
REQ-011 uo_out  output  8  7-segment drive: [0]..[6] = segments a..g, [7] = decimal point.
REQ-012 uio_out  output  8  tied to 8'h00.
REQ-013 uio_oe  output  8  tied to 8'h00 (all uio pins are inputs).

Function
REQ-014 A cycle with load=1 SHALL, at the edge:
  - set pattern to uio_in[MAX_LEN-1:0] and len to min(ui_in[6:4]+1, MAX_LEN);
  - clear history fill, match counter, overflow flag and hold counter.
REQ-015 When load and valid are both 1, load SHALL take priority and the sample SHALL be discarded.
REQ-016 A cycle with valid=1 and load=0 SHALL shift x into the history register at bit 0 (hist <= {hist[MAX_LEN-2:0], x}) and increment fill, saturating at MAX_LEN.
REQ-017 Cycles with valid=0 SHALL leave history and fill unchanged; no detection occurs.
REQ-018 Match SHALL be evaluated on next-state history: next_fill >= len and next_hist[len-1:0] == pattern[len-1:0]; pattern[len-1] is the oldest (first received) bit.
REQ-019 Detect SHALL be registered at the same edge the completing sample is accepted (latency 1 cycle from sample presentation); detect is a single-cycle pulse.
REQ-020 Overlap mode 1: history and fill SHALL be retained after a match. Overlap mode 0: fill SHALL be cleared at the matching edge, so the next match needs len fresh samples.
REQ-021 Each detect SHALL increment the CNT_W-bit match counter modulo 2^CNT_W.
REQ-022 On wrap from all-ones to 0, the sticky overflow flag SHALL set; it clears only on load or reset.
REQ-023 Each detect SHALL load the hold counter with 2^HOLD_W-1; otherwise it decrements to 0 and stops. A retrigger mid-hold SHALL reload it.
REQ-024 Display select 0: uo_out[6:0] SHALL be the hex glyph (0-F) of the low 4 bits of the match counter; uo_out[7] = overflow flag.
REQ-025 Display select 1: uo_out SHALL be 8'hFF ("8.") while the hold counter is nonzero, else 8'h40 ("-").
REQ-026 uo_out SHALL be combinational from registered state and ui_in[7] only.

Reset
REQ-027 While rst_n=0 at an edge, the block SHALL set:
  - pattern=PAT_RST, len=LEN_RST;
  - history, fill, match counter, overflow flag, hold counter and detect all 0.
REQ-028 Reset SHALL take priority over load and valid; a sequence in progress is abandoned.
REQ-029 After reset, uo_out SHALL be 8'h3F with select 0, and 8'h40 with select 1.

Structure
REQ-030 Shared package tt3515_pkg SHALL hold:
  - segment constants SEG_DASH=8'h40 and SEG_ALL=8'hFF;
  - the 16-entry hex glyph table.
REQ-031 The hex-to-segment lookup SHALL be a sub-module named seg7_hex_decoder (4-bit in, 7-bit out).
REQ-032 The remaining logic (pattern registers, history, counters, hold) SHALL sit in the top module.

Verification
REQ-033 Reset, select 0, valid samples 1,0,0 -> detect pulse one cycle after the third sample; uo_out 8'h3F then 8'h06.
REQ-034 Load pattern 8'h05, length field 2 (pattern 101), overlap=1; feed 1,0,1,0,1 -> 2 detects, count=2. Same stream with overlap=0 -> 1 detect.
REQ-035 Default pattern; issue 16 detects -> count wraps to 0; uo_out = 8'hBF (glyph 0 with dp); a load then gives 8'h3F.
REQ-036 Select 1, one detect -> uo_out 8'hFF for 7 cycles, then 8'h40. A second detect at hold cycle 4 -> reload, 8'hFF for 7 more cycles.
REQ-037 load and valid together with x=1 -> sample dropped and fill=0; the next 3 samples 1,0,0 are required for a detect.
REQ-038 Assert rst_n=0 after samples 1,0 -> no detect on a following 0; uio_out and uio_oe stay 8'h00 throughout.
